icache_direct_mapped: RTL and testbench

//  Direct-mapped, one-word-per-block instruction cache between the pipelined datapath fetch port
//  and the memory controller's instruction port. Supplies imemload/ihit to the datapath, which

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/icache_frames.sv | 47 ++++
 rtl/icache_direct_mapped.sv | 119 +++++++++++
 tb/tb_icache_direct_mapped.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type plus the instruction-cache address split and geometry.
package cpu_types_pkg;

    localparam int CPU_WORD_W   = 32;
    localparam int ICACHE_NSETS = 16;
    localparam int ICACHE_IDXW  = $clog2(ICACHE_NSETS);
    localparam int ICACHE_TAGW  = CPU_WORD_W - ICACHE_IDXW - 2;

    typedef logic [CPU_WORD_W-1:0] word_t;

    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

endpackage

// File: rtl/icache_frames.sv
// Frame storage for the direct-mapped icache: valid/tag/data arrays with one
// combinational read port, one synchronous write port and a synchronous clear-all.
import cpu_types_pkg::*;

module icache_frames #(
    parameter int NSETS  = ICACHE_NSETS,
    parameter int WORD_W = CPU_WORD_W,
    parameter int IDXW   = $clog2(NSETS),
    parameter int TAGW   = WORD_W - IDXW - 2
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [IDXW-1:0]   rd_idx,
    output logic              rd_valid,
    output logic [TAGW-1:0]   rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDXW-1:0]   wr_idx,
    input  logic [TAGW-1:0]   wr_tag,
    input  logic [WORD_W-1:0] wr_data
);

    logic [NSETS-1:0]  valid;
    logic [TAGW-1:0]   tag_arr  [NSETS];
    logic [WORD_W-1:0] data_arr [NSETS];

    // Clear beats a coinciding write, so a flushed fill leaves its frame invalid.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_arr[wr_idx]  <= wr_tag;
            data_arr[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_data  = data_arr[rd_idx];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, one-word-per-block instruction cache with a two-state miss FSM,
// same-cycle fill bypass and a saturating hit counter.
import cpu_types_pkg::*;

module icache_direct_mapped #(
    parameter int NSETS  = ICACHE_NSETS,
    parameter int WORD_W = CPU_WORD_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dp_imemREN,
    input  logic [WORD_W-1:0] dp_imemaddr,
    input  logic              dp_flush,
    output logic              dp_ihit,
    output logic [WORD_W-1:0] dp_imemload,
    output logic              mem_iREN,
    output logic [WORD_W-1:0] mem_iaddr,
    input  logic              mem_iwait,
    input  logic [WORD_W-1:0] mem_iload,
    output logic [31:0]       hit_count
);

    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = WORD_W - IDXW - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state;
    logic [WORD_W-1:0] miss_addr;

    logic              rd_valid;
    logic [TAGW-1:0]   rd_tag;
    logic [WORD_W-1:0] rd_data;
    logic              lookup_hit;
    logic              fill_done;
    logic [1:0]        unused_bytoff;

    assign unused_bytoff = dp_imemaddr[1:0];

    icache_frames #(
        .NSETS  (NSETS),
        .WORD_W (WORD_W),
        .IDXW   (IDXW),
        .TAGW   (TAGW)
    ) u_frames (
        .clk      (CLK),
        .clear    (RST | dp_flush),
        .rd_idx   (dp_imemaddr[IDXW+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_done & ~RST),
        .wr_idx   (miss_addr[IDXW+1:2]),
        .wr_tag   (miss_addr[WORD_W-1:IDXW+2]),
        .wr_data  (mem_iload)
    );

    assign lookup_hit = dp_imemREN && rd_valid && (rd_tag == dp_imemaddr[WORD_W-1:IDXW+2]);

    // Bypass during the fill cycle only when the fetch still targets the missed word.
    always_comb begin
        dp_ihit     = 1'b0;
        dp_imemload = '0;
        mem_iREN    = 1'b0;
        mem_iaddr   = '0;
        fill_done   = 1'b0;
        case (state)
            IDLE: begin
                if (lookup_hit) begin
                    dp_ihit     = 1'b1;
                    dp_imemload = rd_data;
                end
            end
            FETCH: begin
                mem_iREN  = 1'b1;
                mem_iaddr = miss_addr;
                if (!mem_iwait) begin
                    fill_done = 1'b1;
                    if (dp_imemREN && (dp_imemaddr[WORD_W-1:2] == miss_addr[WORD_W-1:2])) begin
                        dp_ihit     = 1'b1;
                        dp_imemload = mem_iload;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dp_imemREN && !lookup_hit) begin
                        miss_addr <= {dp_imemaddr[WORD_W-1:2], 2'b00};
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!mem_iwait) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || dp_flush) begin
            hit_count <= '0;
        end else if (dp_ihit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped: directed fetch sequences push expected
// ihit cycles/data into a queue that a negedge monitor pops and compares.
module tb_icache_direct_mapped;

    logic        clk;
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_en   = 0;
    logic [31:0] exp_hits = 0;
    bit          cur_hit, cur_flush, cur_rst;

    icache_direct_mapped dut (
        .CLK         (clk),
        .RST         (rst),
        .dp_imemREN  (ren),
        .dp_imemaddr (addr),
        .dp_flush    (flush),
        .dp_ihit     (ihit),
        .dp_imemload (imemload),
        .mem_iREN    (mem_ren),
        .mem_iaddr   (mem_addr),
        .mem_iwait   (iwait),
        .mem_iload   (iload),
        .hit_count   (hit_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every monitored cycle compares dp_ihit (and data when a hit is due) with the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            bit due;
            due = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
            checks++;
            if (due) begin
                exp_t e;
                e = sb_q.pop_front();
                if (!ihit) begin
                    failures++;
                    $display("[TB] FAIL ihit_missing cyc=%0d actual ihit=%0b required 1", cyc, ihit);
                end else if (imemload !== e.data) begin
                    failures++;
                    $display("[TB] FAIL imemload cyc=%0d actual %h required %h", cyc, imemload, e.data);
                end
            end else if (ihit !== 1'b0) begin
                failures++;
                $display("[TB] FAIL ihit_unexpected cyc=%0d actual ihit=%0b required 0", cyc, ihit);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual %h required %h", name, cyc, act, exp);
        end
    endtask

    // Drives one cycle's inputs and registers an expected hit; settles 1 time unit.
    task automatic apply_stimulus(input bit r, input bit rn, input logic [31:0] a, input bit fl,
                                  input bit w, input logic [31:0] ld,
                                  input bit hit, input logic [31:0] data);
        exp_t e;
        rst = r; ren = rn; addr = a; flush = fl; iwait = w; iload = ld;
        cur_hit = hit; cur_flush = fl; cur_rst = r;
        if (hit) begin
            e.cyc = cyc;
            e.data = data;
            sb_q.push_back(e);
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_rst || cur_flush) exp_hits = 0;
        else if (cur_hit) exp_hits = exp_hits + 1;
        #1;
    endtask

    initial begin
        rst = 1; ren = 0; addr = 0; flush = 0; iwait = 0; iload = 0;
        #1;
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0); tick();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0); tick();
        mon_en = 1;

        // Reset state
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("reset_iren", {31'd0, mem_ren}, 0);
        check_output("reset_iaddr", mem_addr, 0);
        check_output("reset_load", imemload, 0);
        check_output("reset_hitcount", hit_count, 0);
        tick();

        // 1: cold miss on 0x40 with three wait cycles, bypass hit on the fill cycle
        apply_stimulus(0, 1, 32'h40, 0, 1, 0, 0, 0);
        check_output("t1_idle_iren", {31'd0, mem_ren}, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 1, 32'h40, 0, 1, 32'hBAD0_0000, 0, 0);
            check_output("t1_fetch_iren", {31'd0, mem_ren}, 1);
            check_output("t1_fetch_iaddr", mem_addr, 32'h40);
            tick();
        end
        apply_stimulus(0, 1, 32'h40, 0, 0, 32'h2001_0005, 1, 32'h2001_0005);
        check_output("t1_fill_iaddr", mem_addr, 32'h40);
        tick();

        // 2: re-fetch hits with no memory request
        apply_stimulus(0, 1, 32'h40, 0, 0, 0, 1, 32'h2001_0005);
        check_output("t2_hit_iren", {31'd0, mem_ren}, 0);
        check_output("t2_hitcount_before", hit_count, 32'd1);
        tick();
        check_output("t2_hitcount_after", hit_count, exp_hits);

        // 3: same index, other tag replaces the frame; 0x40 misses afterwards
        apply_stimulus(0, 1, 32'h440, 0, 0, 0, 0, 0); tick();
        apply_stimulus(0, 1, 32'h440, 0, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        check_output("t3_fill_iaddr", mem_addr, 32'h440);
        tick();
        apply_stimulus(0, 1, 32'h40, 0, 0, 0, 0, 0);
        check_output("t3_remiss_iren", {31'd0, mem_ren}, 0);
        tick();
        apply_stimulus(0, 1, 32'h40, 0, 0, 32'h2001_0005, 1, 32'h2001_0005); tick();
        apply_stimulus(0, 1, 32'h40, 0, 0, 0, 1, 32'h2001_0005); tick();

        // 4: redirect to 0x100 during the 0x80 fill
        apply_stimulus(0, 1, 32'h80, 0, 0, 0, 0, 0); tick();
        apply_stimulus(0, 1, 32'h100, 0, 1, 0, 0, 0);
        check_output("t4_redirect_iaddr", mem_addr, 32'h80);
        tick();
        apply_stimulus(0, 1, 32'h100, 0, 0, 32'h1111_2222, 0, 0);
        check_output("t4_fill_iaddr", mem_addr, 32'h80);
        tick();
        apply_stimulus(0, 1, 32'h80, 0, 0, 0, 1, 32'h1111_2222); tick();
        apply_stimulus(0, 1, 32'h100, 0, 0, 0, 0, 0); tick();
        apply_stimulus(0, 1, 32'h100, 0, 0, 32'h3333_4444, 1, 32'h3333_4444); tick();

        // REN dropped during a fill: fill completes silently, later hits
        apply_stimulus(0, 1, 32'h200, 0, 0, 0, 0, 0); tick();
        apply_stimulus(0, 0, 32'h200, 0, 0, 32'h0000_0055, 0, 0); tick();
        apply_stimulus(0, 1, 32'h200, 0, 0, 0, 1, 32'h0000_0055); tick();
        check_output("t4_hitcount", hit_count, exp_hits);

        // 5: flush in the fill cycle of 0x0C
        apply_stimulus(0, 1, 32'h0C, 0, 0, 0, 0, 0); tick();
        apply_stimulus(0, 1, 32'h0C, 1, 0, 32'h0C0C_0C0C, 1, 32'h0C0C_0C0C); tick();
        apply_stimulus(0, 1, 32'h0C, 0, 0, 0, 0, 0);
        check_output("t5_hitcount_flushed", hit_count, 32'd0);
        check_output("t5_remiss_iren", {31'd0, mem_ren}, 0);
        tick();
        apply_stimulus(0, 1, 32'h0C, 0, 0, 32'h0C0C_0C0D, 1, 32'h0C0C_0C0D); tick();
        apply_stimulus(0, 1, 32'h200, 0, 0, 0, 0, 0); tick();
        apply_stimulus(0, 1, 32'h200, 0, 0, 32'h0000_0056, 1, 32'h0000_0056); tick();
        check_output("t5_hitcount", hit_count, 32'd2);

        // 6: reset during FETCH
        apply_stimulus(0, 1, 32'h340, 0, 0, 0, 0, 0); tick();
        apply_stimulus(1, 1, 32'h340, 0, 1, 0, 0, 0);
        check_output("t6_fetch_iren", {31'd0, mem_ren}, 1);
        tick();
        apply_stimulus(0, 1, 32'h0C, 0, 0, 0, 0, 0);
        check_output("t6_after_rst_iren", {31'd0, mem_ren}, 0);
        check_output("t6_hitcount", hit_count, 32'd0);
        tick();
        apply_stimulus(0, 1, 32'h0C, 0, 0, 32'h0000_0077, 1, 32'h0000_0077); tick();
        apply_stimulus(0, 1, 32'h340, 0, 0, 0, 0, 0);
        check_output("t6_340_miss_iren", {31'd0, mem_ren}, 0);
        tick();
        apply_stimulus(0, 0, 32'h340, 0, 0, 32'h0000_0088, 0, 0);
        check_output("t6_340_iaddr", mem_addr, 32'h340);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); tick();
        check_output("final_hitcount", hit_count, exp_hits);

        @(negedge clk);
        mon_en = 0;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual %0d pending required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
